tt_nco: RTL and testbench
=========================

TT_NCO -- requirements
Module: tt_nco

Interface
Parameters:
REQ-001 SHALL have parameter ACC_W, default 24: phase accumulator width in bits.
REQ-002 SHALL have parameter CTRL_W, default 16: signed control word width in bits.
REQ-003 SHALL have parameter GAIN_SHIFT, default 4: left shift applied to control before summing with base.

Ports:
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_enable  in  1  run request.
REQ-007 SHALL have port i_fcw_base  in  ACC_W  unsigned centre frequency control word.
REQ-008 SHALL have port i_control  in  CTRL_W  signed PI controller output.
REQ-009 SHALL have port i_ctrl_valid  in  1  capture strobe for i_control.
REQ-010 SHALL have port o_clk_gen  out  1  generated square wave, equal to accumulator MSB.
REQ-011 SHALL have port o_tick  out  1  one-cycle pulse per output period.
REQ-012 SHALL have port o_phase  out  ACC_W  current accumulator value.
REQ-013 SHALL have port o_running  out  1  high in RUN or DRAIN.
REQ-014 SHALL have port o_sat  out  1  active FCW was clamped.

Function
REQ-015 SHALL register i_control into ctrl_q on every cycle with i_ctrl_valid=1, in any state.
REQ-016 SHALL compute fcw_next = i_fcw_base + (sign-extended ctrl_q <<< GAIN_SHIFT) in ACC_W+CTRL_W+GAIN_SHIFT+1 signed bits, with no intermediate overflow.
REQ-017 SHALL clamp fcw_next to the range [1, 2^(ACC_W-1)] and flag sat_next=1 when clamping occurs.
REQ-018 SHALL implement states IDLE, RUN and DRAIN.
REQ-019 In IDLE: acc=0 and o_clk_gen=0; i_enable=1 SHALL move to RUN next cycle, loading active_fcw and o_sat from fcw_next and sat_next.
REQ-020 In RUN/DRAIN: acc SHALL be updated each cycle as acc <= (acc + active_fcw) mod 2^ACC_W.
REQ-021 A wrap (carry out of ACC_W bits) SHALL cause o_tick=1 on the following cycle only.
REQ-022 active_fcw and o_sat SHALL reload from fcw_next only on wrap cycles, so a control change never alters a period already in progress.
REQ-023 RUN with i_enable=0 SHALL move to DRAIN; accumulation continues.
REQ-024 DRAIN with i_enable=1 SHALL return to RUN with acc preserved and no phase discontinuity.
REQ-025 DRAIN with a wrap and i_enable=0 SHALL move to IDLE with acc cleared, so the output stops low after a complete period.
REQ-026 If a wrap and re-enable occur in the same DRAIN cycle, the design SHALL go to RUN (re-enable wins).
REQ-027 o_clk_gen, o_tick, o_running and o_sat SHALL all be registered outputs (no combinational paths from inputs).

Reset
REQ-028 i_rst=1 SHALL asynchronously force state=IDLE, acc=0, ctrl_q=0, active_fcw=1, and all outputs to 0.
REQ-029 Reset asserted mid-period SHALL truncate the output immediately; the first rising edge after release SHALL be no earlier than 2 cycles after i_enable is sampled high.

Structure
REQ-030 Shared package tt_dco_pkg SHALL hold the state enum, the FCW_MIN constant (1), and a function returning FCW_MAX for a given ACC_W.
REQ-031 The saturating add/clamp SHALL be a combinational sub-module named tt_fcw_clamp; all registers SHALL live in tt_nco.
REQ-032 The design SHALL be fully synthesizable: no delays, no combinational loops.

Verification (bench parameters ACC_W=8, CTRL_W=16, GAIN_SHIFT=0)
REQ-033 Base=32, control=0, enable=1: o_clk_gen SHALL show period 8 (4 high / 4 low), o_tick every 8 cycles, o_sat=0.
REQ-034 Control=+32 with valid pulse mid-period: the current period SHALL complete at 8 cycles, then the period SHALL be 4.
REQ-035 Control=-100 gives fcw clamped to 1 (period 256, o_sat=1); control=+200 gives fcw clamped to 128 (period 2, o_sat=1).
REQ-036 Enable dropped while o_clk_gen=1: ticking SHALL continue to the wrap, then o_running=0 and o_clk_gen=0.
REQ-037 Enable reasserted in DRAIN: the period SHALL stay uninterrupted and the state SHALL return to RUN.
REQ-038 i_rst pulsed mid-RUN: all outputs SHALL be 0 within the same cycle; re-enabling SHALL restart from phase 0.

Source files
------------

// File: rtl/tt_dco_pkg.sv
// Shared definitions for the numerically controlled oscillator: state
// encoding and the legal frequency-control-word bounds.
package tt_dco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } nco_state_t;

    // Smallest FCW the oscillator may run with; zero would stall the phase.
    localparam logic [63:0] FCW_MIN = 64'd1;

    // Largest FCW for a given accumulator width: half a turn per cycle,
    // which is the fastest square wave the accumulator MSB can represent.
    function automatic logic [63:0] fcw_max(input int unsigned acc_w);
        return 64'd1 << (acc_w - 32'd1);
    endfunction

endpackage

// File: rtl/tt_fcw_clamp.sv
// Combinational saturating adder: centre FCW plus scaled signed control,
// clamped to [FCW_MIN, fcw_max(ACC_W)] with a flag when clamping happens.
module tt_fcw_clamp #(
    parameter int ACC_W      = 24,
    parameter int CTRL_W     = 16,
    parameter int GAIN_SHIFT = 4
) (
    input  logic [ACC_W-1:0]         fcw_base,
    input  logic signed [CTRL_W-1:0] ctrl,
    output logic [ACC_W-1:0]         fcw,
    output logic                     sat
);
    import tt_dco_pkg::*;

    // Wide enough that neither the shift nor the addition can overflow.
    localparam int SUM_W = ACC_W + CTRL_W + GAIN_SHIFT + 1;

    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(FCW_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(fcw_max(ACC_W));

    logic signed [SUM_W-1:0] base_s;
    logic signed [SUM_W-1:0] ctrl_s;
    logic signed [SUM_W-1:0] sum_s;

    assign base_s = signed'({{(SUM_W-ACC_W){1'b0}}, fcw_base});
    assign ctrl_s = signed'({{(SUM_W-CTRL_W){ctrl[CTRL_W-1]}}, ctrl}) <<< GAIN_SHIFT;
    assign sum_s  = base_s + ctrl_s;

    // Clamp the full-precision sum into the legal FCW range.
    always_comb begin
        fcw = sum_s[ACC_W-1:0];
        sat = 1'b0;
        if (sum_s < MIN_S) begin
            fcw = MIN_S[ACC_W-1:0];
            sat = 1'b1;
        end else if (sum_s > MAX_S) begin
            fcw = MAX_S[ACC_W-1:0];
            sat = 1'b1;
        end else begin
            fcw = sum_s[ACC_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/tt_nco.sv
// Numerically controlled oscillator: phase accumulator whose MSB is the
// generated clock. FCW changes only take effect at period boundaries, and a
// disable lets the current period finish before stopping low.
module tt_nco #(
    parameter int ACC_W      = 24,
    parameter int CTRL_W     = 16,
    parameter int GAIN_SHIFT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [ACC_W-1:0]         i_fcw_base,
    input  logic signed [CTRL_W-1:0] i_control,
    input  logic                     i_ctrl_valid,
    output logic                     o_clk_gen,
    output logic                     o_tick,
    output logic [ACC_W-1:0]         o_phase,
    output logic                     o_running,
    output logic                     o_sat
);
    import tt_dco_pkg::*;

    localparam logic [ACC_W-1:0] FCW_RST = ACC_W'(FCW_MIN);

    nco_state_t               state_r;
    nco_state_t               state_s;
    logic [ACC_W-1:0]         acc_r;
    logic [ACC_W-1:0]         acc_s;
    logic signed [CTRL_W-1:0] ctrl_r;
    logic [ACC_W-1:0]         active_fcw_r;
    logic                     clk_gen_r;
    logic                     tick_r;
    logic                     running_r;
    logic                     sat_r;

    logic [ACC_W:0]           sum_s;
    logic                     wrap_s;
    logic                     load_s;
    logic                     tick_s;
    logic [ACC_W-1:0]         clamp_fcw_s;
    logic                     clamp_sat_s;

    tt_fcw_clamp #(
        .ACC_W      (ACC_W),
        .CTRL_W     (CTRL_W),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_clamp (
        .fcw_base (i_fcw_base),
        .ctrl     (ctrl_r),
        .fcw      (clamp_fcw_s),
        .sat      (clamp_sat_s)
    );

    // One extra bit catches the carry that marks the end of a period.
    assign sum_s  = {1'b0, acc_r} + {1'b0, active_fcw_r};
    assign wrap_s = sum_s[ACC_W];

    // Next-state, next-phase and FCW-reload decisions.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        load_s  = 1'b0;
        tick_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                acc_s = {ACC_W{1'b0}};
                if (i_enable) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_s  = sum_s[ACC_W-1:0];
                tick_s = wrap_s;
                load_s = wrap_s;
                if (!i_enable) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                acc_s  = sum_s[ACC_W-1:0];
                tick_s = wrap_s;
                load_s = wrap_s;
                if (i_enable) begin
                    // Re-enable wins even on a wrap cycle; phase carries on.
                    state_s = ST_RUN;
                end else if (wrap_s) begin
                    state_s = ST_IDLE;
                    acc_s   = {ACC_W{1'b0}};
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                acc_s   = {ACC_W{1'b0}};
            end
        endcase
    end

    // Control word capture, independent of oscillator state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (i_ctrl_valid) begin
            ctrl_r <= i_control;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Oscillator state, phase and period-boundary FCW reload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            acc_r        <= {ACC_W{1'b0}};
            active_fcw_r <= FCW_RST;
            sat_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            if (load_s) begin
                active_fcw_r <= clamp_fcw_s;
                sat_r        <= clamp_sat_s;
            end else begin
                active_fcw_r <= active_fcw_r;
                sat_r        <= sat_r;
            end
        end
    end

    // Registered status outputs, each computed from next-state values so
    // they line up with the phase register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_gen_r <= 1'b0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            clk_gen_r <= acc_s[ACC_W-1];
            tick_r    <= tick_s;
            running_r <= (state_s != ST_IDLE);
        end
    end

    assign o_clk_gen = clk_gen_r;
    assign o_tick    = tick_r;
    assign o_phase   = acc_r;
    assign o_running = running_r;
    assign o_sat     = sat_r;

endmodule

// File: tb/tb_tt_nco.sv
// Directed bench for tt_nco with ACC_W=8, CTRL_W=16, GAIN_SHIFT=0.
`timescale 1ns/1ps
module tb_tt_nco;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [7:0]         fcw_base;
    logic signed [15:0] control;
    logic               ctrl_valid;
    logic               clk_gen;
    logic               tick;
    logic [7:0]         phase;
    logic               running;
    logic               sat;

    int checks;
    int errors;
    int n;
    int per;
    int hi;

    tt_nco #(.ACC_W(8), .CTRL_W(16), .GAIN_SHIFT(0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_fcw_base   (fcw_base),
        .i_control    (control),
        .i_ctrl_valid (ctrl_valid),
        .o_clk_gen    (clk_gen),
        .o_tick       (tick),
        .o_phase      (phase),
        .o_running    (running),
        .o_sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Count falling edges until o_tick is seen (bounded).
    task automatic cyc_to_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tick && cnt < 600);
    endtask

    // Starting on a tick sample, measure period length and high cycles.
    task automatic meas_period(output int p, output int h);
        p = 0;
        h = 0;
        do begin
            h += int'(clk_gen);
            p++;
            @(negedge clk);
        end while (!tick && p < 600);
    endtask

    task automatic pulse_ctrl(input logic signed [15:0] val);
        control    = val;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        fcw_base   = 8'd32;
        control    = 16'sd0;
        ctrl_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_phase",   32'(phase),   32'd0);
        check_eq("rst_clk_gen", 32'(clk_gen), 32'd0);
        check_eq("rst_tick",    32'(tick),    32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_sat",     32'(sat),     32'd0);

        // Base 32, control 0: period 8, 4 high
        rst        = 1'b0;
        ctrl_valid = 1'b1;
        enable     = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
        check_eq("start_running", 32'(running), 32'd1);
        check_eq("start_phase",   32'(phase),   32'd0);
        cyc_to_tick(n);
        check_eq("first_period", 32'(n), 32'd8);
        check_eq("base_sat", 32'(sat), 32'd0);
        meas_period(per, hi);
        check_eq("base_period", 32'(per), 32'd8);
        check_eq("base_high",   32'(hi),  32'd4);

        // Control +32 mid-period: this period stays 8, next is 4
        n = 0;
        @(negedge clk);
        n++;
        check_eq("tick_one_cycle", 32'(tick), 32'd0);
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        control    = 16'sd32;
        ctrl_valid = 1'b1;
        @(negedge clk);
        n++;
        ctrl_valid = 1'b0;
        while (!tick && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq("midchange_period", 32'(n), 32'd8);
        meas_period(per, hi);
        check_eq("fast_period", 32'(per), 32'd4);
        check_eq("fast_high",   32'(hi),  32'd2);
        check_eq("fast_sat",    32'(sat), 32'd0);

        // Control -100: clamp to FCW 1 after the current 4-cycle period
        pulse_ctrl(-16'sd100);
        cyc_to_tick(n);
        check_eq("lo_prev_rest", 32'(n),   32'd3);
        check_eq("lo_sat",       32'(sat), 32'd1);
        meas_period(per, hi);
        check_eq("lo_period", 32'(per), 32'd256);
        check_eq("lo_high",   32'(hi),  32'd128);

        // Control +200: clamp to FCW 128
        pulse_ctrl(16'sd200);
        cyc_to_tick(n);
        check_eq("hi_prev_rest", 32'(n),   32'd255);
        check_eq("hi_sat",       32'(sat), 32'd1);
        meas_period(per, hi);
        check_eq("hi_period", 32'(per), 32'd2);
        check_eq("hi_high",   32'(hi),  32'd1);

        // Back to base 32, then drop enable while output is high
        pulse_ctrl(16'sd0);
        cyc_to_tick(n);
        check_eq("back_prev_rest", 32'(n),   32'd1);
        check_eq("back_sat",       32'(sat), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("drain_pre_high", 32'(clk_gen), 32'd1);
        enable = 1'b0;
        cyc_to_tick(n);
        check_eq("drain_to_wrap",  32'(n),       32'd4);
        check_eq("drain_stop_run", 32'(running), 32'd0);
        check_eq("drain_stop_clk", 32'(clk_gen), 32'd0);
        check_eq("drain_stop_ph",  32'(phase),   32'd0);
        @(negedge clk);
        check_eq("idle_tick",    32'(tick),    32'd0);
        check_eq("idle_running", 32'(running), 32'd0);

        // Restart from IDLE, then re-enable during DRAIN
        enable = 1'b1;
        cyc_to_tick(n);
        check_eq("restart_first", 32'(n), 32'd9);
        n = 0;
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        check_eq("redrain_running", 32'(running), 32'd1);
        enable = 1'b1;
        while (!tick && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq("reenable_period", 32'(n), 32'd8);
        meas_period(per, hi);
        check_eq("reenable_next", 32'(per),     32'd8);
        check_eq("reenable_run",  32'(running), 32'd1);

        // Asynchronous reset mid-RUN, then restart from phase 0
        repeat (5) @(negedge clk);
        check_eq("prerst_high", 32'(clk_gen), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_clk_gen", 32'(clk_gen), 32'd0);
        check_eq("arst_phase",   32'(phase),   32'd0);
        check_eq("arst_running", 32'(running), 32'd0);
        check_eq("arst_tick",    32'(tick),    32'd0);
        check_eq("arst_sat",     32'(sat),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_phase0",  32'(phase),   32'd0);
        check_eq("post_rst_running", 32'(running), 32'd1);
        @(negedge clk);
        check_eq("post_rst_phase1", 32'(phase), 32'd32);
        cyc_to_tick(n);
        check_eq("post_rst_wrap", 32'(n), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
